// File: rtl/mu0_mem_responder.sv
// MU0 memory-side responder: on-chip RAM below IO_BASE plus a console TX FIFO, STATUS and TX_COUNT I/O window.
// Define MU0_MEM_TIMER_EN to add the free-running cycle timer at IO_BASE+3.
module mu0_mem_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [11:0] IO_BASE    = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] address,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RAM_WORDS = 32'(IO_BASE);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  localparam logic [11:0] OFF_TX_DATA  = 12'd0;
  localparam logic [11:0] OFF_STATUS   = 12'd1;
  localparam logic [11:0] OFF_TX_COUNT = 12'd2;
`ifdef MU0_MEM_TIMER_EN
  localparam logic [11:0] OFF_TIMER    = 12'd3;
`endif

  logic [15:0]      ram      [RAM_WORDS];
  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic        is_io;
  logic [11:0] io_off;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        ram_we;
  logic        status_we;

  // Address decode and FIFO handshake
  assign is_io      = (address >= IO_BASE);
  assign io_off     = address - IO_BASE;
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_valid ? fifo_mem[rd_ptr] : 16'h0000;
  assign pop        = tx_valid && tx_ready;
  assign push_req   = memory_write && is_io && (io_off == OFF_TX_DATA);
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push       = push_req && (!fifo_full || pop);
  assign status_we  = memory_write && is_io && (io_off == OFF_STATUS);
  assign ram_we     = memory_write && !is_io && !rst;

  // RAM: no reset, contents survive rst
  always_ff @(posedge clk) begin
    if (ram_we) ram[address] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (status_we)
        overflow <= 1'b0;
      else if (push_req && !push)
        overflow <= 1'b1;
    end
  end

`ifdef MU0_MEM_TIMER_EN
  logic [15:0] timer;
  logic        timer_we;

  assign timer_we = memory_write && is_io && (io_off == OFF_TIMER);

  // Free-running cycle counter; a CPU write reloads it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      timer <= 16'h0000;
    else if (timer_we)
      timer <= wr_data;
    else
      timer <= timer + 16'd1;
  end
`endif

  // Zero-latency read mux; reads never change state
  always_comb begin
    rd_data = 16'h0000;
    if (memory_read) begin
      if (!is_io) begin
        rd_data = ram[address];
      end else begin
        case (io_off)
          OFF_STATUS:   rd_data = {13'b0, overflow, fifo_full, fifo_empty};
          OFF_TX_COUNT: rd_data = 16'(count);
`ifdef MU0_MEM_TIMER_EN
          OFF_TIMER:    rd_data = timer;
`endif
          default:      rd_data = 16'h0000;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mu0_mem_responder.sv
// Scoreboard bench for mu0_mem_responder: directed scenarios then random traffic against a queue-based model.
module tb_mu0_mem_responder;

  localparam int unsigned DEPTH = 8;
  localparam logic [11:0] IOB   = 12'hFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] address;
  logic        memory_read;
  logic        memory_write;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  mu0_mem_responder #(.FIFO_DEPTH(DEPTH), .IO_BASE(IOB)) dut (
    .clk(clk), .rst(rst), .address(address), .memory_read(memory_read),
    .memory_write(memory_write), .wr_data(wr_data), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  // Reference model state
  logic [15:0] mem [int];
  logic [15:0] mq[$];
  logic        m_ovf;
  logic [15:0] m_timer;

  // Expected-response queues
  logic [15:0] rd_q[$];
  logic [16:0] vq[$];
  logic [15:0] drain_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [11:0] a);
    int off;
    if (a < IOB) return mem[int'(a)];
    off = int'(a - IOB);
    case (off)
      1: return {13'b0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
      2: return 16'(mq.size());
`ifdef MU0_MEM_TIMER_EN
      3: return m_timer;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  // Drive one cycle at the falling edge and advance the model across the next rising edge
  task automatic cycle(input bit rd, input bit wr, input logic [11:0] a, input logic [15:0] d, input bit rdy);
    bit pp, full, acc;
    memory_read = rd; memory_write = wr; address = a; wr_data = d; tx_ready = rdy;
    if (rd) rd_q.push_back(model_read(a));
    vq.push_back({mq.size() != 0, (mq.size() != 0) ? mq[0] : 16'h0000});
    pp = rdy && (mq.size() != 0);
    if (pp) drain_q.push_back(mq[0]);
    full = (mq.size() == DEPTH);
    acc  = wr && (a == IOB) && (!full || pp);
    if (wr && (a == IOB) && !acc) m_ovf = 1'b1;
    if (wr && (a == IOB + 12'd1)) m_ovf = 1'b0;
    if (pp) void'(mq.pop_front());
    if (acc) mq.push_back(d);
    if (wr && (a < IOB)) mem[int'(a)] = d;
    if (wr && (a == IOB + 12'd3)) m_timer = d;
    else m_timer = m_timer + 16'd1;
    @(negedge clk);
  endtask

  // Reset asserted across a rising edge while a RAM write is presented
  task automatic reset_mid(input logic [11:0] ra, input logic [15:0] junk);
    mon_en = 1'b0;
    rst = 1'b1; memory_read = 1'b0; memory_write = 1'b1; address = ra; wr_data = junk; tx_ready = 1'b1;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    @(posedge clk); #1;
    memory_write = 1'b0; memory_read = 1'b1; address = IOB + 12'd2;
    #1;
    chk("rst_tx_count", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_timer = 16'h0000;
    mon_en = 1'b1;
  endtask

  // Monitor: samples just before each rising edge and pops expectations
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk); #4;
      if (mon_en) begin
        if (memory_read) begin
          if (rd_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_q: read with no expectation at %0t", $time);
          end else chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end else begin
          chk("rd_idle", 32'(rd_data), 32'd0);
        end
        if (vq.size() != 0) begin
          e = vq.pop_front();
          chk("tx_valid", 32'(tx_valid), 32'(e[16]));
          chk("tx_data", 32'(tx_data), 32'(e[15:0]));
        end
        if (tx_valid && tx_ready) begin
          if (drain_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: unexpected word %h at %0t", tx_data, $time);
          end else chk("drain", 32'(tx_data), 32'(drain_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [11:0] ram_set [6];
    logic [11:0] a;
    int sel;
    bit rd, wr;
    ram_set = '{12'h000, 12'h123, 12'h050, 12'hFEF, 12'h7A5, 12'h3C0};

    rst = 1'b1; memory_read = 1'b0; memory_write = 1'b0; address = '0; wr_data = '0; tx_ready = 1'b0;
    m_ovf = 1'b0; m_timer = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_rd_idle", 32'(rd_data), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    cycle(1'b1, 1'b0, IOB + 12'd1, 16'h0, 1'b0);        // STATUS after reset: empty
    // RAM round trip
    cycle(1'b0, 1'b1, 12'h123, 16'hBEEF, 1'b0);
    cycle(1'b1, 1'b0, 12'h123, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 12'h123, 16'h0, 1'b0);
    // FIFO ordering
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, IOB, 16'(i), 1'b0);
    cycle(1'b1, 1'b0, IOB + 12'd2, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, IOB + 12'd1, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, IOB, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, IOB + 12'd1, 16'h0, 1'b1);
    // Overflow and clear
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, IOB, 16'h0010 + 16'(i), 1'b0);
    cycle(1'b1, 1'b0, IOB + 12'd1, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, IOB + 12'd1, 16'h1234, 1'b0);
    cycle(1'b1, 1'b0, IOB + 12'd1, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 12'h0, 16'h0, 1'b1);
    // Full with simultaneous pop
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, IOB, 16'h0100 + 16'(i), 1'b0);
    cycle(1'b0, 1'b1, IOB, 16'hAAAA, 1'b1);
    cycle(1'b1, 1'b0, IOB + 12'd2, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, IOB + 12'd1, 16'h0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 12'h0, 16'h0, 1'b1);
    // Reset mid-operation
    cycle(1'b0, 1'b1, 12'h050, 16'h1234, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, IOB, 16'h0200 + 16'(i), 1'b0);
    reset_mid(12'h050, 16'hDEAD);
    cycle(1'b1, 1'b0, 12'h050, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, IOB + 12'd2, 16'h0, 1'b1);
    // Timer load and wrap
    cycle(1'b0, 1'b1, IOB + 12'd3, 16'hFFFE, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, IOB + 12'd3, 16'h0, 1'b0);

    // Random traffic
    repeat (600) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: a = ram_set[$urandom_range(0, 5)];
        3, 4:    a = IOB;
        5:       a = IOB + 12'd1;
        6:       a = IOB + 12'd2;
        7:       a = IOB + 12'd3;
        default: a = IOB + 12'($urandom_range(4, 15));
      endcase
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ((a < IOB) && !mem.exists(int'(a))) rd = 1'b0;
      if ((sel == 5) && wr && ($urandom_range(0, 3) != 0)) wr = 1'b0;
      cycle(rd, wr, a, 16'($urandom), $urandom_range(0, 2) == 0);
    end

    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 12'h0, 16'h0, 1'b1);
    #6;
    chk("drain_leftover", 32'(drain_q.size()), 32'd0);
    chk("rd_leftover", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
